// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and hazard detection for a 5-stage MIPS pipeline.
// For each of NSRC ID-stage source operands, picks EX, MEM, WB or register-file data.
// Stalls ID on load-use hazards and on RAW/structural hazards against one
// in-flight multi-cycle MDU op. Also keeps a saturating count of stall cycles.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_valid, flush               ID instruction valid / killed this cycle
//   id_src_addr, id_src_used      ID source operands (operand i at [i*AW +: AW])
//   id_mdu_issue, id_mdu_waddr    ID instruction is an MDU op, and its destination
//   ex_wen, ex_waddr, ex_is_load  EX-stage producer
//   mem_wen, mem_waddr            MEM-stage producer
//   wb_wen, wb_waddr              WB-stage producer
//   fwd_sel                       per operand: 00 regfile, 01 EX, 10 MEM, 11 WB (combinational)
//   stall                         hold PC and IF/ID, bubble into EX (combinational)
//   mdu_busy                      MDU scoreboard entry valid
//   stall_cnt                     saturating stall-cycle counter
module fwd_hazard_unit #(
    parameter int unsigned NSRC    = 2,
    parameter int unsigned AW      = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src_addr,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 id_mdu_issue,
    input  logic [AW-1:0]        id_mdu_waddr,
    input  logic                 flush,
    input  logic                 ex_wen,
    input  logic [AW-1:0]        ex_waddr,
    input  logic                 ex_is_load,
    input  logic                 mem_wen,
    input  logic [AW-1:0]        mem_waddr,
    input  logic                 wb_wen,
    input  logic [AW-1:0]        wb_waddr,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 mdu_busy,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int unsigned LAT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    logic                mdu_busy_q, mdu_busy_d;
    logic [LAT_W-1:0]    mdu_cnt_q,  mdu_cnt_d;
    logic [AW-1:0]       mdu_dest_q, mdu_dest_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NSRC*2-1:0]   fwd_sel_c;
    logic                load_use_c;
    logic                mdu_raw_c;
    logic                mdu_struct_c;
    logic                stall_c;
    logic                mdu_accept_c;

    // Forwarding select and per-operand hazard detection; youngest producer wins.
    always_comb begin
        fwd_sel_c  = '0;
        load_use_c = 1'b0;
        mdu_raw_c  = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (id_src_used[i] && (id_src_addr[i*AW +: AW] != '0)) begin
                if (ex_wen && (ex_waddr == id_src_addr[i*AW +: AW])) begin
                    // Load data is not ready in EX; leave regfile select and stall instead.
                    if (ex_is_load) begin
                        load_use_c = 1'b1;
                    end else begin
                        fwd_sel_c[i*2 +: 2] = 2'b01;
                    end
                end else if (mem_wen && (mem_waddr == id_src_addr[i*AW +: AW])) begin
                    fwd_sel_c[i*2 +: 2] = 2'b10;
                end else if (wb_wen && (wb_waddr == id_src_addr[i*AW +: AW])) begin
                    fwd_sel_c[i*2 +: 2] = 2'b11;
                end
                if (mdu_busy_q && (mdu_dest_q == id_src_addr[i*AW +: AW])) begin
                    mdu_raw_c = 1'b1;
                end
            end
        end
    end

    assign mdu_struct_c = id_mdu_issue && mdu_busy_q;
    assign stall_c      = rst_n && id_valid && !flush && (load_use_c || mdu_raw_c || mdu_struct_c);
    assign mdu_accept_c = id_valid && id_mdu_issue && !stall_c && !flush;

    // Combinational outputs are forced low while reset is held.
    assign fwd_sel   = rst_n ? fwd_sel_c : '0;
    assign stall     = stall_c;
    assign mdu_busy  = mdu_busy_q;
    assign stall_cnt = stall_cnt_q;

    // MDU scoreboard next state: busy for exactly MDU_LAT cycles after acceptance.
    always_comb begin
        mdu_busy_d = mdu_busy_q;
        mdu_cnt_d  = mdu_cnt_q;
        mdu_dest_d = mdu_dest_q;
        if (mdu_accept_c) begin
            mdu_busy_d = 1'b1;
            mdu_cnt_d  = LAT_W'(MDU_LAT - 1);
            mdu_dest_d = id_mdu_waddr;
        end else if (mdu_busy_q) begin
            if (mdu_cnt_q == '0) begin
                mdu_busy_d = 1'b0;
            end else begin
                mdu_cnt_d = mdu_cnt_q - LAT_W'(1);
            end
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_busy_q  <= 1'b0;
            mdu_cnt_q   <= '0;
            mdu_dest_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            mdu_busy_q  <= mdu_busy_d;
            mdu_cnt_q   <= mdu_cnt_d;
            mdu_dest_q  <= mdu_dest_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
